// File: rtl/fp_mul_scheduler_if.sv
// Request/response bundle between requesters and the shared FP multiplier scheduler.
// Requester i owns bit i of the per-requester vectors and 32-bit slice i of the operand buses.
interface fp_mul_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_mode;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_result;
  logic [2:0]            rsp_flags;

  modport master (
    output req_valid, req_mode, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_mode, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
  );
endinterface

// File: rtl/fp_mul_scheduler.sv
// Round-robin scheduler sharing one pipelined FP multiplier between NUM_REQ requesters.
// Ops in flight always share one precision mode; a mode change drains the pipe first.
module fp_mul_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  fp_mul_scheduler_if.slave bus,
  output logic              mul_sign_a,
  output logic              mul_sign_b,
  output logic [7:0]        mul_exp_a,
  output logic [7:0]        mul_exp_b,
  output logic [22:0]       mul_mant_a,
  output logic [22:0]       mul_mant_b,
  output logic              mul_mode_fp,
  output logic              mul_round_mode,
  input  logic              mul_result_sign,
  input  logic [7:0]        mul_result_exp,
  input  logic [22:0]       mul_result_mant,
  input  logic              mul_overflow,
  input  logic              mul_underflow,
  input  logic              mul_inexact,
  output logic              cur_mode,
  output logic              busy
);

  localparam int              DEPTH    = MUL_LAT + 1;
  localparam int              CNT_W    = $clog2(DEPTH + 1);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q;
  logic                 lock_vld_q;
  logic [ID_W-1:0]      lock_idx_q;
  logic                 cur_mode_q;
  logic [CNT_W-1:0]     inflight_q;
  logic                 sh_vld_q [DEPTH];
  logic [ID_W-1:0]      sh_id_q  [DEPTH];

  logic [2*NUM_REQ-1:0] valid_rot;
  logic                 cand_found;
  logic [ID_W-1:0]      cand_idx;
  logic                 cand_mode;
  logic [31:0]          op_a, op_b;
  logic                 grant;
  logic                 lock_set;
  logic                 rsp_fire;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= unsigned'(NUM_REQ)) s = s - unsigned'(NUM_REQ);
    return ID_W'(s);
  endfunction

  // Rotating the doubled valid vector by rr_ptr turns the wrap-around search into a plain
  // lowest-set-bit scan; a locked requester overrides the search so it cannot be bypassed.
  always_comb begin
    valid_rot  = {bus.req_valid, bus.req_valid} >> rr_ptr_q;
    cand_found = 1'b0;
    cand_idx   = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!cand_found && valid_rot[k]) begin
        cand_found = 1'b1;
        cand_idx   = wrap_add(rr_ptr_q, k);
      end
    end
    if (lock_vld_q) begin
      cand_found = bus.req_valid[lock_idx_q];
      cand_idx   = lock_idx_q;
    end
  end

  assign cand_mode = bus.req_mode[cand_idx];
  assign op_a      = bus.req_a[32*cand_idx +: 32];
  assign op_b      = bus.req_b[32*cand_idx +: 32];
  assign rsp_fire  = sh_vld_q[DEPTH-1];

  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    lock_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (cand_found) begin
          grant   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cand_found && (cand_mode == cur_mode_q)) begin
          grant = 1'b1;
        end else if (cand_found) begin
          lock_set = 1'b1;
          state_d  = DRAIN;
        end else if (rsp_fire && (inflight_q == ONE)) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (inflight_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      grant    = 1'b0;
      lock_set = 1'b0;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready[cand_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_mode_q <= 1'b1;
      rr_ptr_q   <= '0;
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
      inflight_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        rr_ptr_q   <= (cand_idx == LAST_IDX) ? '0 : cand_idx + 1'b1;
        lock_vld_q <= 1'b0;
        if (state_q == IDLE) cur_mode_q <= cand_mode;
      end
      if (lock_set) begin
        lock_vld_q <= 1'b1;
        lock_idx_q <= cand_idx;
      end
      case ({grant, rsp_fire})
        2'b10:   inflight_q <= inflight_q + ONE;
        2'b01:   inflight_q <= inflight_q - ONE;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Shadow pipe carries the owner id alongside the multiplier, one stage per latency cycle
  // plus the operand register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_sign_a <= 1'b0;
      mul_sign_b <= 1'b0;
      mul_exp_a  <= '0;
      mul_exp_b  <= '0;
      mul_mant_a <= '0;
      mul_mant_b <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        sh_vld_q[k] <= 1'b0;
        sh_id_q[k]  <= '0;
      end
    end else begin
      if (grant) begin
        {mul_sign_a, mul_exp_a, mul_mant_a} <= op_a;
        {mul_sign_b, mul_exp_b, mul_mant_b} <= op_b;
      end
      sh_vld_q[0] <= grant;
      sh_id_q[0]  <= cand_idx;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        sh_vld_q[k] <= sh_vld_q[k-1];
        sh_id_q[k]  <= sh_id_q[k-1];
      end
    end
  end

  assign bus.rsp_valid  = rsp_fire & ~rst;
  assign bus.rsp_id     = sh_id_q[DEPTH-1];
  assign bus.rsp_result = {mul_result_sign, mul_result_exp, mul_result_mant};
  assign bus.rsp_flags  = {mul_overflow, mul_underflow, mul_inexact};

  assign mul_mode_fp    = cur_mode_q;
  assign mul_round_mode = 1'b0;
  assign cur_mode       = cur_mode_q;
  assign busy           = (inflight_q != '0) || (state_q == DRAIN);

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));
  a_inflight_max: assert property (@(posedge clk) disable iff (rst) inflight_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Randomized bench for fp_mul_scheduler: a transaction-level reference model predicts grants,
// mode changes and responses; a small bench-side multiplier stands in for fp_multiplier.
module tb_fp_mul_scheduler;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mul_sign_a, mul_sign_b, mul_mode_fp, mul_round_mode;
  logic [7:0]  mul_exp_a, mul_exp_b;
  logic [22:0] mul_mant_a, mul_mant_b;
  logic        cur_mode, busy;
  logic [34:0] st1, st2;

  fp_mul_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  fp_mul_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .mul_sign_a      (mul_sign_a),
    .mul_sign_b      (mul_sign_b),
    .mul_exp_a       (mul_exp_a),
    .mul_exp_b       (mul_exp_b),
    .mul_mant_a      (mul_mant_a),
    .mul_mant_b      (mul_mant_b),
    .mul_mode_fp     (mul_mode_fp),
    .mul_round_mode  (mul_round_mode),
    .mul_result_sign (st2[34]),
    .mul_result_exp  (st2[33:26]),
    .mul_result_mant (st2[25:3]),
    .mul_overflow    (st2[2]),
    .mul_underflow   (st2[1]),
    .mul_inexact     (st2[0]),
    .cur_mode        (cur_mode),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Truncating single-precision multiply for normal operands: {sign,exp,mant,ovf,unf,inexact}.
  function automatic logic [34:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    logic [7:0]  ex;
    logic        ovf, unf, inex;
    int          e;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m    = p[46:24];
      inex = |p[23:0];
      e    = e + 1;
    end else begin
      m    = p[45:23];
      inex = |p[22:0];
    end
    ovf = (e > 254);
    unf = (e < 1);
    ex  = e[7:0];
    if (ovf) begin
      ex = 8'hFF;
      m  = '0;
    end else if (unf) begin
      ex = 8'h00;
      m  = '0;
    end
    return {a[31] ^ b[31], ex, m, ovf, unf, inex};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      st1 <= '0;
      st2 <= '0;
    end else begin
      st1 <= fmul({mul_sign_a, mul_exp_a, mul_mant_a}, {mul_sign_b, mul_exp_b, mul_mant_b});
      st2 <= st1;
    end
  end

  typedef struct {
    int          id;
    logic [31:0] res;
    logic [2:0]  flg;
    int          due;
  } exp_t;

  // reference model state
  exp_t        m_q[$];
  bit          m_mode;
  int          m_ptr;
  bit          m_drain;
  int          m_lock;
  logic [31:0] m_last_a, m_last_b;
  int          cyc;
  int          gcyc[NUM_REQ];
  int          gcnt[NUM_REQ];

  // requester state
  bit          pend[NUM_REQ];
  bit          pmode[NUM_REQ];
  logic [31:0] pa[NUM_REQ];
  logic [31:0] pb[NUM_REQ];
  bit          gen_en;
  bit          p_mode;
  int unsigned p_new, p_flip;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          t1_chk = 1'b0;
  int          t1_hits = 0;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    if ($urandom_range(9) == 0) e = 8'($urandom_range(254, 1));
    else                        e = 8'($urandom_range(154, 100));
    return {1'($urandom_range(1)), e, 23'($urandom)};
  endfunction

  task automatic new_req(input int i, input bit mode);
    pend[i]  = 1'b1;
    pmode[i] = mode;
    pa[i]    = rand_fp();
    pb[i]    = rand_fp();
  endtask

  task automatic apply();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i]         = pend[i];
      bus.req_mode[i]          = pmode[i];
      bus.req_a[32*i +: 32]    = pa[i];
      bus.req_b[32*i +: 32]    = pb[i];
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode   = 1'b1;
    m_ptr    = 0;
    m_drain  = 1'b0;
    m_lock   = -1;
    m_last_a = '0;
    m_last_b = '0;
  endtask

  function automatic bit any_pend();
    bit r = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) r |= pend[i];
    return r;
  endfunction

  // One clock cycle: predict and compare at negedge, advance model at posedge, then drive.
  task automatic tick();
    int                 cand, gnt;
    bit                 idle, sdrain, dexit, exp_rv;
    logic [NUM_REQ-1:0] er;
    logic [34:0]        r;
    exp_t               e;
    @(negedge clk);
    cand = -1;
    if (m_lock >= 0) begin
      if (pend[m_lock]) cand = m_lock;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx = (m_ptr + k) % NUM_REQ;
        if (cand < 0 && pend[idx]) cand = idx;
      end
    end
    idle   = (m_q.size() == 0) && !m_drain;
    gnt    = -1;
    sdrain = 1'b0;
    dexit  = m_drain && (m_q.size() == 0);
    if (!rst && !m_drain && cand >= 0) begin
      if (idle || pmode[cand] == m_mode) gnt = cand;
      else sdrain = 1'b1;
    end
    er = '0;
    if (gnt >= 0) er[gnt] = 1'b1;
    exp_rv = !rst && (m_q.size() > 0) && (m_q[0].due == cyc);

    chk_eq("req_ready", 64'(bus.req_ready), 64'(er));
    chk_eq("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
    if (exp_rv) begin
      chk_eq("rsp_id", 64'(bus.rsp_id), 64'(m_q[0].id));
      chk_eq("rsp_result", 64'(bus.rsp_result), 64'(m_q[0].res));
      chk_eq("rsp_flags", 64'(bus.rsp_flags), 64'(m_q[0].flg));
      if (t1_chk) begin
        t1_hits++;
        chk_eq("t1_result", 64'(bus.rsp_result), 64'(32'h40C00000));
        chk_eq("t1_flags", 64'(bus.rsp_flags), 64'(3'b000));
      end
    end
    chk_eq("cur_mode", 64'(cur_mode), 64'(m_mode));
    chk_eq("mul_mode_fp", 64'(mul_mode_fp), 64'(m_mode));
    chk_eq("busy", 64'(busy), 64'((m_q.size() != 0) || m_drain));
    chk_eq("mul_a", 64'({mul_sign_a, mul_exp_a, mul_mant_a}), 64'(m_last_a));
    chk_eq("mul_b", 64'({mul_sign_b, mul_exp_b, mul_mant_b}), 64'(m_last_b));
    chk_eq("round_mode", 64'(mul_round_mode), 64'(0));

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (exp_rv) void'(m_q.pop_front());
      if (dexit) m_drain = 1'b0;
      if (gnt >= 0) begin
        if (idle) m_mode = pmode[gnt];
        r     = fmul(pa[gnt], pb[gnt]);
        e.id  = gnt;
        e.res = r[34:3];
        e.flg = r[2:0];
        e.due = cyc + MUL_LAT + 1;
        m_q.push_back(e);
        m_ptr    = (gnt + 1) % NUM_REQ;
        m_lock   = -1;
        m_last_a = pa[gnt];
        m_last_b = pb[gnt];
        gcyc[gnt] = cyc;
        gcnt[gnt]++;
      end
      if (sdrain) begin
        m_drain = 1'b1;
        m_lock  = cand;
      end
    end
    cyc++;
    #1;
    if (gnt >= 0) pend[gnt] = 1'b0;
    if (gen_en && !rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && $urandom_range(99) < p_new)
          new_req(i, ($urandom_range(99) < p_flip) ? !p_mode : p_mode);
      end
    end
    apply();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      if (!((m_q.size() != 0) || m_drain || any_pend())) break;
      tick();
    end
    chk_eq("idle_wait", 64'({busy, any_pend()}), 64'(2'b00));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, a_id;
    rst    = 1'b1;
    gen_en = 1'b0;
    p_mode = 1'b1;
    p_new  = 70;
    p_flip = 10;
    cyc    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i]  = 1'b0;
      pmode[i] = 1'b1;
      pa[i]    = '0;
      pb[i]    = '0;
      gcyc[i]  = 0;
      gcnt[i]  = 0;
    end
    model_reset();
    apply();
    repeat (3) tick();
    rst = 1'b0;

    // T1: 2.0 * 3.0 on requester 0, single precision
    pend[0] = 1'b1; pmode[0] = 1'b1; pa[0] = 32'h40000000; pb[0] = 32'h40400000;
    apply();
    t1_chk = 1'b1;
    repeat (6) tick();
    t1_chk = 1'b0;
    chk_eq("t1_seen", 64'(t1_hits), 64'(1));

    // T2/T4: both requesters stream in the same mode
    gen_en = 1'b1; p_new = 100; p_flip = 0; p_mode = 1'b1;
    repeat (40) tick();
    gen_en = 1'b0;
    wait_idle();

    // T3: single op on req0, then half-precision op on req1 forces a drain
    new_req(0, 1'b1);
    apply();
    tick();
    new_req(1, 1'b0);
    apply();
    repeat (5) tick();
    chk_eq("t3_gap", 64'(gcyc[1] - gcyc[0]), 64'(5));
    chk_eq("t3_mode", 64'(cur_mode), 64'(0));
    wait_idle();

    // T6: req1 waits on a mode change while req0 keeps streaming
    new_req(0, 1'b0);
    apply();
    repeat (3) begin
      tick();
      if (!pend[0]) begin new_req(0, 1'b0); apply(); end
    end
    new_req(1, 1'b1);
    apply();
    g0 = gcnt[0];
    for (int k = 0; k < 20 && pend[1]; k++) begin
      tick();
      if (!pend[0] && pend[1]) begin new_req(0, 1'b0); apply(); end
    end
    chk_eq("t6_served", 64'(pend[1]), 64'(0));
    chk_eq("t6_no_bypass", 64'(gcnt[0] - g0), 64'(0));
    wait_idle();

    // T5: reset right after a grant discards the op
    new_req(0, 1'b0);
    apply();
    tick();
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    apply();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk_eq("t5_mode", 64'(cur_mode), 64'(1));
    chk_eq("t5_busy", 64'(busy), 64'(0));

    // randomized traffic with mode flips and occasional resets
    gen_en = 1'b1; p_new = 60; p_flip = 15;
    for (int c = 0; c < 1500; c++) begin
      if (c % 250 == 249) p_mode = !p_mode;
      if ($urandom_range(399) == 0) begin
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
        apply();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    gen_en = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
